clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-of-day set-mode controller (optional idle abort: CLKSET_TIMEOUT_EN)
module clock_set_ctrl #(
  parameter int BLINK_HALF = 12500000,
  parameter int TIMEOUT    = 250000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  input  logic        key_dec,
  input  logic [31:0] cur_time,
  output logic        run_en,
  output logic        load,
  output logic [31:0] load_data,
  output logic [3:0]  blink_mask,
  output logic [31:0] edit_time
);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SET_HH = 3'd1;
  localparam logic [2:0] SET_MM = 3'd2;
  localparam logic [2:0] SET_SS = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  localparam logic [7:0]  HH_MAX     = 8'd23;
  localparam logic [7:0]  MS_MAX     = 8'd59;
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);

  // Reject parameter values that would break the blink or abort timing.
  if (BLINK_HALF < 2 || TIMEOUT < 2) begin : g_param_check
    $error("clock_set_ctrl: BLINK_HALF and TIMEOUT must be >= 2");
  end

  logic [2:0]  state_q, state_d;
  logic [31:0] edit_q, edit_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;

  logic        in_set, in_set_next, any_key, step, enter_set, timeout_hit;
  logic [7:0]  fld_val, fld_max, fld_new;

  // Saturating-wrap step helpers; out-of-range values snap to 0 (inc) or max (dec).
  function automatic logic [7:0] f_inc(input logic [7:0] v, input logic [7:0] m);
    return (v >= m) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [7:0] f_dec(input logic [7:0] v, input logic [7:0] m);
    return (v == 8'd0 || v > m) ? m : v - 8'd1;
  endfunction

  assign in_set  = (state_q == SET_HH) || (state_q == SET_MM) || (state_q == SET_SS);
  assign any_key = key_mode | key_inc | key_dec;
  // Simultaneous inc+dec cancels and does not count as an edit.
  assign step    = in_set & ~key_mode & (key_inc ^ key_dec);

  // Pick the field currently under edit and its upper bound.
  always_comb begin
    fld_val = 8'd0;
    fld_max = MS_MAX;
    case (state_q)
      SET_HH: begin fld_val = edit_q[31:24]; fld_max = HH_MAX; end
      SET_MM: fld_val = edit_q[23:16];
      SET_SS: fld_val = edit_q[15:8];
      default: fld_val = 8'd0;
    endcase
    fld_new = key_inc ? f_inc(fld_val, fld_max) : f_dec(fld_val, fld_max);
  end

`ifdef CLKSET_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] to_cnt_q, to_cnt_d;

  assign timeout_hit = in_set & ~any_key & (to_cnt_q == TO_LAST);

  // Idle counter: restarts on any key or SET entry, counts only while editing.
  always_comb begin
    to_cnt_d = to_cnt_q + 32'd1;
    if (any_key || enter_set || !in_set_next) to_cnt_d = 32'd0;
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= 32'd0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, edit register and committed value.
  always_comb begin
    state_d     = state_q;
    edit_d      = edit_q;
    load_data_d = load_data_q;
    enter_set   = 1'b0;
    case (state_q)
      RUN: begin
        if (key_mode) begin
          state_d   = SET_HH;
          edit_d    = cur_time;
          enter_set = 1'b1;
        end
      end
      SET_HH: begin
        if (key_mode) begin
          state_d   = SET_MM;
          enter_set = 1'b1;
        end else if (timeout_hit) begin
          state_d = RUN;
        end else if (step) begin
          edit_d[31:24] = fld_new;
        end
      end
      SET_MM: begin
        if (key_mode) begin
          state_d   = SET_SS;
          enter_set = 1'b1;
        end else if (timeout_hit) begin
          state_d = RUN;
        end else if (step) begin
          edit_d[23:16] = fld_new;
        end
      end
      SET_SS: begin
        if (key_mode) begin
          state_d     = COMMIT;
          load_data_d = {edit_q[31:8], 8'd0};
        end else if (timeout_hit) begin
          state_d = RUN;
        end else if (step) begin
          edit_d[15:8] = fld_new;
        end
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
    in_set_next = (state_d == SET_HH) || (state_d == SET_MM) || (state_d == SET_SS);
  end

  // Blink timer: idle outside SET states, restarted by field entry or an edit.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 32'd1;
    phase_d     = phase_q;
    if (!in_set_next || enter_set || step) begin
      blink_cnt_d = 32'd0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = 32'd0;
      phase_d     = ~phase_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      edit_q      <= 32'd0;
      load_data_q <= 32'd0;
      blink_cnt_q <= 32'd0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      load_data_q <= load_data_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Blank only the field being edited, and only in the off phase.
  always_comb begin
    blink_mask = 4'b0000;
    case (state_q)
      SET_HH:  blink_mask = {phase_q, 3'b000};
      SET_MM:  blink_mask = {1'b0, phase_q, 2'b00};
      SET_SS:  blink_mask = {2'b00, phase_q, 1'b0};
      default: blink_mask = 4'b0000;
    endcase
  end

  assign run_en    = (state_q == RUN);
  assign load      = (state_q == COMMIT);
  assign load_data = load_data_q;
  assign edit_time = run_en ? cur_time : edit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed-vector bench for clock_set_ctrl
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_mode = 1'b0;
  logic        key_inc = 1'b0;
  logic        key_dec = 1'b0;
  logic [31:0] cur_time = 32'd0;
  logic        run_en, load;
  logic [31:0] load_data, edit_time;
  logic [3:0]  blink_mask;

  int n_vec = 0;
  int n_bad = 0;
  int load_pulses = 0;

  clock_set_ctrl #(.BLINK_HALF(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .cur_time(cur_time), .run_en(run_en), .load(load), .load_data(load_data),
    .blink_mask(blink_mask), .edit_time(edit_time)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load) load_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic keys(input logic m, input logic i, input logic d);
    key_mode = m; key_inc = i; key_dec = d;
    tick();
    key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    cur_time = 32'h173B3B05;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_run_en", {31'd0, run_en}, 32'd1);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mask", {28'd0, blink_mask}, 32'd0);
    check("rst_edit_time", edit_time, 32'h173B3B05);

    // Full edit/commit pass with wraps at each field.
    keys(1, 0, 0);
    check("hh_run_en", {31'd0, run_en}, 32'd0);
    check("hh_capture", edit_time, 32'h173B3B05);
    keys(0, 1, 0);
    check("hh_wrap_inc", edit_time, 32'h003B3B05);
    keys(1, 0, 0);
    keys(0, 1, 0);
    check("mm_wrap_inc", edit_time, 32'h00003B05);
    keys(1, 0, 0);
    keys(0, 0, 1);
    check("ss_dec", edit_time, 32'h00003A05);
    keys(1, 0, 0);
    check("commit_load", {31'd0, load}, 32'd1);
    check("commit_data", load_data, 32'h00003A00);
    check("commit_run_en", {31'd0, run_en}, 32'd0);
    check("commit_mask", {28'd0, blink_mask}, 32'd0);
    tick();
    check("post_commit_run_en", {31'd0, run_en}, 32'd1);
    check("post_commit_load", {31'd0, load}, 32'd0);
    check("load_data_hold", load_data, 32'h00003A00);
    check("load_pulse_count1", load_pulses, 32'd1);

    // Mode beats inc; inc+dec cancels; dec wraps 0 -> 59.
    cur_time = 32'h0A001E00;
    keys(1, 0, 0);
    keys(1, 1, 0);
    check("mode_prio_hh", edit_time, 32'h0A001E00);
    check("enter_mm_mask", {28'd0, blink_mask}, 32'd0);
    keys(0, 1, 1);
    check("mm_inc_dec_same", edit_time, 32'h0A001E00);
    keys(0, 0, 1);
    check("mm_wrap_dec", edit_time, 32'h0A3B1E00);

    // Reset mid-edit discards the edit without a load.
    do_reset();
    check("abort_run_en", {31'd0, run_en}, 32'd1);
    check("abort_load", {31'd0, load}, 32'd0);
    check("abort_load_data", load_data, 32'd0);
    check("abort_mask", {28'd0, blink_mask}, 32'd0);
    check("abort_no_pulse", load_pulses, 32'd1);

    // Blink cadence in SET_SS and restart on an edit.
    cur_time = 32'h01020304;
    keys(1, 0, 0);
    keys(1, 0, 0);
    keys(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("blink_idle_%0d", i), {28'd0, blink_mask}, (i >= 4) ? 32'd2 : 32'd0);
      if (i < 5) tick();
    end
    keys(0, 1, 0);
    check("blink_edit_val", edit_time, 32'h01020404);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("blink_restart_%0d", j), {28'd0, blink_mask}, (j == 4) ? 32'd2 : 32'd0);
      if (j < 4) tick();
    end
    do_reset();

    // Idle in SET_HH: abort to RUN with the option, stay otherwise.
    keys(1, 0, 0);
    check("idle_enter", {31'd0, run_en}, 32'd0);
`ifdef CLKSET_TIMEOUT_EN
    repeat (15) tick();
    check("idle_before_to", {31'd0, run_en}, 32'd0);
    tick();
    check("idle_timeout", {31'd0, run_en}, 32'd1);
    check("idle_no_load", load_pulses, 32'd1);
`else
    repeat (1000) tick();
    check("idle_stay", {31'd0, run_en}, 32'd0);
    check("idle_mask_hh_only", {28'd0, blink_mask & 4'b0111}, 32'd0);
    check("idle_no_load", load_pulses, 32'd1);
`endif
    do_reset();

    // Out-of-range fields snap to max on dec and 0 on inc.
    cur_time = 32'h1F3C0000;
    keys(1, 0, 0);
    keys(0, 0, 1);
    check("hh_over_dec", edit_time, 32'h173C0000);
    keys(1, 0, 0);
    keys(0, 1, 0);
    check("mm_over_inc", edit_time, 32'h17000000);
    do_reset();
    check("final_no_load", load_pulses, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
